// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a first-word-fall-through receive FIFO.
// Reports bad stop bits (frame_err) and bytes dropped on a full FIFO (overflow).
module uart_rx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rx,
   output logic [7:0]                    m_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic                          frame_err,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [15:0] HALF_M1  = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] FULL_M1  = 16'(CLKS_PER_BIT - 1);
   localparam logic [AW:0] DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_n;
   logic [15:0]   cnt, cnt_n;
   logic [2:0]    bit_idx, bit_n;
   logic [7:0]    shreg, shreg_n;
   logic          stop_hit;
   logic          rx_meta, rx_s;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          pop, push, full, stop_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_n;
         shreg   <= shreg_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      bit_n    = bit_idx;
      shreg_n  = shreg;
      stop_hit = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_n = START;
               cnt_n   = '0;
            end
         end
         START: begin
            // Mid-start-bit check rejects line glitches shorter than half a bit.
            if (cnt == HALF_M1) begin
               cnt_n   = '0;
               bit_n   = '0;
               state_n = rx_s ? IDLE : DATA;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         DATA: begin
            if (cnt == FULL_M1) begin
               cnt_n   = '0;
               shreg_n = {rx_s, shreg[7:1]};
               bit_n   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_n = STOP;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         STOP: begin
            if (cnt == FULL_M1) begin
               cnt_n    = '0;
               stop_hit = 1'b1;
               state_n  = IDLE;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign m_valid = (count != '0);
   assign full    = (count == DEPTH_C);
   assign pop     = m_valid & m_ready;
   assign stop_ok = stop_hit & rx_s;
   // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
   assign push    = stop_ok & (~full | pop);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= shreg;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         frame_err <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         frame_err <= stop_hit & ~rx_s;
         overflow  <= stop_ok & full & ~pop;
      end
   end

   assign m_data     = m_valid ? mem[rd_ptr] : '0;
   assign fifo_count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (CLKS_PER_BIT=8, FIFO_DEPTH=4):
// directed scenarios followed by random frames against a queue-based model.
module tb_uart_rx_fifo;

   localparam int unsigned CPB   = 8;
   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       frame_err;
   logic       overflow;
   logic [2:0] fifo_count;

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .frame_err  (frame_err),
      .overflow   (overflow),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int n_ferr = 0, n_ovf = 0;
   int exp_ferr = 0, exp_ovf = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_pop[$];
   logic [7:0] exp_q[$];
   logic       hold_prev = 1'b0;
   logic [7:0] hold_data = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Consumer-side monitor: records pops and pulse counts, checks head stability.
   always @(negedge clk) begin
      if (rst_n) begin
         if (frame_err) n_ferr++;
         if (overflow)  n_ovf++;
         if (m_valid && m_ready) got_q.push_back(m_data);
         if (hold_prev && m_valid) chk("hold_stable", m_data, hold_data);
         hold_prev = m_valid && !m_ready;
         hold_data = m_data;
      end else begin
         hold_prev = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives the first n_ticks clocks of an 8N1 frame; m_ready rises at tick ready_k.
   task automatic send_frame(input logic [7:0] d, input logic stop, input int ready_k,
                             input int n_ticks);
      for (int k = 0; k < n_ticks; k++) begin
         automatic int b = k / 8;
         rx = (b == 0) ? 1'b0 : (b == 9) ? stop : d[b-1];
         if (k == ready_k) m_ready = 1'b1;
         tick();
      end
      rx = 1'b1;
   endtask

   task automatic model_drain();
      while (exp_q.size() != 0) exp_pop.push_back(exp_q.pop_front());
   endtask

   // Effect of one complete frame with m_ready held constant for its duration.
   task automatic model_frame(input logic [7:0] d, input logic stop, input logic rdy);
      if (rdy) model_drain();
      if (!stop)                    exp_ferr++;
      else if (rdy)                 exp_pop.push_back(d);
      else if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else                          exp_ovf++;
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_count"}, fifo_count, exp_q.size());
      chk({tag, "_valid"}, m_valid, exp_q.size() != 0);
      chk({tag, "_ferr"}, n_ferr, exp_ferr);
      chk({tag, "_ovf"}, n_ovf, exp_ovf);
      if (exp_q.size() != 0 && !m_ready) chk({tag, "_head"}, m_data, exp_q[0]);
   endtask

   task automatic chk_pops(input string tag);
      chk({tag, "_npop"}, got_q.size(), exp_pop.size());
      for (int i = 0; i < got_q.size() && i < exp_pop.size(); i++)
         chk({tag, "_pop"}, got_q[i], exp_pop[i]);
   endtask

   task automatic frame(input logic [7:0] d, input logic stop, input logic rdy);
      m_ready = rdy;
      send_frame(d, stop, -1, 80);
      model_frame(d, stop, rdy);
      repeat (4) tick();
   endtask

   initial begin
      rst_n   = 1'b0;
      rx      = 1'b1;
      m_ready = 1'b0;
      repeat (3) tick();
      chk("rst_valid", m_valid, 1'b0);
      chk("rst_count", fifo_count, 3'd0);
      chk("rst_data", m_data, 8'h00);
      chk("rst_ferr", frame_err, 1'b0);
      chk("rst_ovf", overflow, 1'b0);
      rst_n = 1'b1;
      repeat (3) tick();

      // Single byte with consumer ready
      frame(8'hA5, 1'b1, 1'b1);
      chk_state("a5");
      chk_pops("a5");

      // Short start glitch
      m_ready = 1'b0;
      rx = 1'b0;
      repeat (3) tick();
      rx = 1'b1;
      repeat (12) tick();
      chk_state("glitch");

      // Bad stop bit
      frame(8'h3C, 1'b0, 1'b0);
      chk_state("ferr");

      // Fill past capacity, then drain
      for (int i = 1; i <= 5; i++) frame(8'(i), 1'b1, 1'b0);
      chk_state("ovf");
      m_ready = 1'b1;
      repeat (8) tick();
      model_drain();
      m_ready = 1'b0;
      chk_state("drain1");
      chk_pops("drain1");

      // Full FIFO with a pop in the stop-sample cycle of the 5th byte
      for (int i = 1; i <= 4; i++) frame(8'(i), 1'b1, 1'b0);
      chk_state("full");
      send_frame(8'h05, 1'b1, 78, 80);
      exp_pop.push_back(exp_q.pop_front());
      exp_q.push_back(8'h05);
      chk("swap_ovf", n_ovf, exp_ovf);
      repeat (8) tick();
      model_drain();
      m_ready = 1'b0;
      chk_state("swap");
      chk_pops("swap");

      // Reset during DATA, with a byte already buffered
      frame(8'h5A, 1'b1, 1'b0);
      chk_state("pre_rst");
      send_frame(8'h77, 1'b1, -1, 40);
      rx = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_count", fifo_count, 3'd0);
      chk("arst_valid", m_valid, 1'b0);
      chk("arst_data", m_data, 8'h00);
      exp_q.delete();
      repeat (3) tick();
      rx = 1'b1;
      rst_n = 1'b1;
      repeat (20) tick();
      chk_state("post_rst");
      frame(8'h12, 1'b1, 1'b0);
      chk_state("after_rst");

      // Random frames
      for (int n = 0; n < 30; n++) begin
         automatic logic [7:0] d    = 8'($urandom);
         automatic logic       stop = ($urandom_range(0, 5) != 0);
         automatic logic       rdy  = ($urandom_range(0, 3) == 0);
         frame(d, stop, rdy);
         repeat ($urandom_range(0, 10)) tick();
         chk_state("rnd");
      end

      m_ready = 1'b1;
      repeat (10) tick();
      model_drain();
      chk_state("final");
      chk_pops("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
